// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: datapath width,
// FSM state encoding and the quotient produced for a zero divisor.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla.sv
// Block carry-lookahead adder: 4-bit groups with group generate/propagate,
// group carries chained across the word. WIDTH must be a multiple of 4.
module cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  always_comb begin
    grp_c[0] = cin;
    for (int k = 1; k < NG; k++) begin
      grp_c[k] = grp_g[k-1] | (grp_p[k-1] & grp_c[k-1]);
    end
  end

  always_comb begin
    logic c;
    // NOTE: every variable gets a value on every path through this block;
    // a path that skips an assignment would make synthesis infer a latch.
    sum = '0;
    c   = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c = grp_c[k];
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ c;
        c          = g[4*k+j] | (p[4*k+j] & c);
      end
    end
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative unsigned 32/32 restoring divider resolving BITS_PER_CYCLE quotient
// bits per clock, with valid/ready handshakes on both sides and a flush.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH / BITS_PER_CYCLE);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // Per-step chain: element k is the value entering step k of this cycle.
  logic [WIDTH-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] dvd_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_c [BITS_PER_CYCLE+1];

  assign rem_c[0] = rem_q;
  assign dvd_c[0] = dividend_q;
  assign quo_c[0] = quo_q;

  // A zero divisor needs no special case: every step sees ge=1 and a
  // difference equal to the shifted remainder, giving all-ones / dividend.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem_c[k], dvd_c[k][WIDTH-1]};
    assign ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor_q);

    cla #(.WIDTH(WIDTH)) u_cla (
      .a   (shifted[WIDTH-1:0]),
      .b   (~divisor_q),
      .cin (1'b1),
      .sum (diff)
    );

    assign rem_c[k+1] = ge ? diff : shifted[WIDTH-1:0];
    assign dvd_c[k+1] = {dvd_c[k][WIDTH-2:0], 1'b0};
    assign quo_c[k+1] = {quo_c[k][WIDTH-2:0], ge};
  end

  assign accept = (state == IDLE) && i_valid && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (i_valid)         state_nxt = BUSY;
        BUSY:    if (cnt_q == 'd1)    state_nxt = DONE;
        DONE:    if (i_ready)         state_nxt = IDLE;
        default:                      state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // NOTE: the datapath registers are reset as well so the result outputs
  // read as zero rather than X before the first division completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      dividend_q <= i_dividend;
      divisor_q  <= i_divisor;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= CNT_INIT;
    end else if (state == BUSY && !i_flush) begin
      dividend_q <= dvd_c[BITS_PER_CYCLE];
      rem_q      <= rem_c[BITS_PER_CYCLE];
      quo_q      <= quo_c[BITS_PER_CYCLE];
      cnt_q      <= cnt_q - 1'b1;
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;

endmodule

// File: doc/div_iter_unit.md
DIV_ITER_UNIT -- requirements
Module: div_iter_unit

Interface
REQ-001 Parameter: BITS_PER_CYCLE, default 1, quotient bits resolved per clock; legal values 1 and 2 only.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_flush  input  1  synchronous abort of any in-flight division.
REQ-005 Port: i_valid  input  1  operands present.
REQ-006 Port: o_ready  output  1  unit can accept operands.
REQ-007 Port: i_dividend  input  32  unsigned dividend.
REQ-008 Port: i_divisor  input  32  unsigned divisor.
REQ-009 Port: o_valid  output  1  result present.
REQ-010 Port: i_ready  input  1  downstream accepts result.
REQ-011 Port: o_quotient  output  32  unsigned quotient.
REQ-012 Port: o_remainder  output  32  unsigned remainder.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-014 IDLE->BUSY when i_valid&o_ready&!i_flush; operands captured that edge; remainder cleared, iteration counter = 32/BITS_PER_CYCLE.
REQ-015 Each BUSY cycle SHALL perform BITS_PER_CYCLE restoring steps: shift remainder left 1, insert dividend MSB, shift dividend left 1.
REQ-016 Each step SHALL form shifted remainder as 33 bits; ge = bit32 | (low32 >= divisor); difference = low32 + ~divisor + 1 computed on a cla instance (modulo 2^32).
REQ-017 If ge, remainder <= difference and quotient bit = 1; else remainder <= low32 and quotient bit = 0; quotient shifts in LSB-first-from-MSB order.
REQ-018 BUSY->DONE on the edge the counter reaches 0; latency accept-edge to o_valid = 32/BITS_PER_CYCLE cycles.
REQ-019 Divisor 0 SHALL still iterate full latency and yield quotient 32'hFFFF_FFFF, remainder = dividend.
REQ-020 DONE holds o_quotient/o_remainder stable until i_valid... correction: until i_ready=1; DONE->IDLE on o_valid&i_ready.
REQ-021 New operands are not accepted in DONE even if i_ready=1 same cycle; next accept earliest the following cycle.
REQ-022 i_flush=1 in any state SHALL force IDLE next edge, discard result, and override a coincident i_valid (no capture).
REQ-023 o_quotient/o_remainder outside DONE are don't-care but SHALL not be X after reset.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, o_valid=0, o_ready=1 (after state settles), quotient, remainder, dividend, divisor, counter = 0.
REQ-025 Reset mid-BUSY or mid-DONE SHALL discard the operation; no o_valid pulse after rst_n rises.
REQ-026 Release of rst_n SHALL permit acceptance on the first following edge.

Structure
REQ-027 Shared package div_pkg SHALL hold WIDTH=32, state enum (IDLE, BUSY, DONE), DIV0_QUOTIENT=32'hFFFF_FFFF.
REQ-028 Subtraction SHALL reuse existing sub-module cla, one instance per step (BITS_PER_CYCLE instances), cin tied 1.
REQ-029 No other arithmetic sub-modules; comparator inline.

Verification
REQ-030 100/7, BITS_PER_CYCLE=1 -> o_valid exactly 32 cycles after accept, quotient 14, remainder 2.
REQ-031 0xFFFF_FFFF/1 and 0x8000_0000/0xFFFF_FFFF -> (0xFFFF_FFFF,0) and (0,0x8000_0000); BITS_PER_CYCLE=2 gives same values in 16 cycles.
REQ-032 1234/0 -> quotient 0xFFFF_FFFF, remainder 1234, full latency.
REQ-033 Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0, i_valid ignored; accept next only after handshake.
REQ-034 i_flush at BUSY cycle 5 with i_valid=1 -> IDLE next edge, no capture, no o_valid; next op 9/3 -> (3,0).
REQ-035 rst_n low mid-BUSY -> o_valid 0 immediately, IDLE; random 10k operand pairs vs reference model match.
